// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one main-memory port between the icache and dcache miss handlers.
//   One line request (icache refill, dcache refill or dcache dirty writeback)
//   is accepted at a time. It is forwarded to memory over a valid/ready request
//   channel, the single response is awaited, and a one-cycle fill/ack pulse is
//   returned to the owner. State sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
//   Handshake: mem_req_valid_out rises when a grant is made and stays high,
//   with mem_we_out/mem_addr_out/mem_wdata_out stable, until mem_req_ready_in
//   is sampled 1 at a rising edge; the request is transferred at that edge.
//   mem_resp_valid_in is a single-cycle strobe that is honoured only in WAIT.
//
//   Build option: define ARB_ROUND_ROBIN_EN to alternate grants on a tie
//   (the side opposite to the last grant wins). Without it, dcache always
//   wins a tie. A lone request is granted immediately in both builds.
//
// Ports
//   clk_in, rst_n_in         clock (rising edge), synchronous active-low reset
//   icache_req_in/addr_in    icache refill request (level) and line address
//   icache_fill_valid_out    one-cycle pulse, icache_fill_data_out valid
//   icache_fill_data_out     refilled line
//   dcache_req_in/we_in      dcache request (level); we=1 writeback, 0 refill
//   dcache_addr_in/wdata_in  line address and writeback data
//   dcache_fill_valid_out    one-cycle pulse: refill data valid or write ack
//   dcache_fill_data_out     refilled line (unchanged on write ack)
//   mem_req_valid_out        request to memory valid
//   mem_req_ready_in         memory accepts the request
//   mem_we_out/addr_out/wdata_out  request fields
//   mem_resp_valid_in/data_in      memory response strobe and read data
//   dbg_state                current FSM state (0 IDLE,1 ISSUE,2 WAIT,3 RESP)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_BITS = 32,
   parameter int LINE_BITS = 128
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 icache_req_in,
   input  logic [ADDR_BITS-1:0] icache_addr_in,
   output logic                 icache_fill_valid_out,
   output logic [LINE_BITS-1:0] icache_fill_data_out,
   input  logic                 dcache_req_in,
   input  logic                 dcache_we_in,
   input  logic [ADDR_BITS-1:0] dcache_addr_in,
   input  logic [LINE_BITS-1:0] dcache_wdata_in,
   output logic                 dcache_fill_valid_out,
   output logic [LINE_BITS-1:0] dcache_fill_data_out,
   output logic                 mem_req_valid_out,
   input  logic                 mem_req_ready_in,
   output logic                 mem_we_out,
   output logic [ADDR_BITS-1:0] mem_addr_out,
   output logic [LINE_BITS-1:0] mem_wdata_out,
   input  logic                 mem_resp_valid_in,
   input  logic [LINE_BITS-1:0] mem_resp_data_in,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               state, state_d;
   logic                 owner_dcache, owner_dcache_d;
   logic                 req_valid_d;
   logic                 we_d;
   logic [ADDR_BITS-1:0] addr_d;
   logic [LINE_BITS-1:0] wdata_d;
   logic                 ifill_valid_d, dfill_valid_d;
   logic [LINE_BITS-1:0] ifill_data_d, dfill_data_d;
   logic                 any_req;
   logic                 grant_dcache;

   assign any_req   = icache_req_in | dcache_req_in;
   assign dbg_state = state;

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers the side of the most recent grant; reset points at dcache so
   // the first tie after reset goes to icache.
   logic last_dcache;

   always_comb begin
      grant_dcache = dcache_req_in;
      if (dcache_req_in && icache_req_in)
         grant_dcache = !last_dcache;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in)
         last_dcache <= 1'b1;
      else if (state == S_IDLE && any_req)
         last_dcache <= grant_dcache;
   end
`else
   // Fixed priority: a dcache miss stalls the whole pipe, so it wins ties.
   always_comb grant_dcache = dcache_req_in;
`endif

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d        = state;
      owner_dcache_d = owner_dcache;
      req_valid_d    = mem_req_valid_out;
      we_d           = mem_we_out;
      addr_d         = mem_addr_out;
      wdata_d        = mem_wdata_out;
      ifill_valid_d  = 1'b0;
      dfill_valid_d  = 1'b0;
      ifill_data_d   = icache_fill_data_out;
      dfill_data_d   = dcache_fill_data_out;

      case (state)
         S_IDLE: begin
            if (any_req) begin
               owner_dcache_d = grant_dcache;
               req_valid_d    = 1'b1;
               // icache only ever refills, so its request is forced to a read.
               we_d           = grant_dcache ? dcache_we_in : 1'b0;
               addr_d         = grant_dcache ? dcache_addr_in : icache_addr_in;
               wdata_d        = grant_dcache ? dcache_wdata_in : '0;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_req_ready_in) begin
               req_valid_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp_valid_in) begin
               state_d = S_RESP;
               if (owner_dcache) begin
                  dfill_valid_d = 1'b1;
                  // A writeback ack carries no data; the previous line is held.
                  if (!mem_we_out)
                     dfill_data_d = mem_resp_data_in;
               end else begin
                  ifill_valid_d = 1'b1;
                  ifill_data_d  = mem_resp_data_in;
               end
            end
         end
         S_RESP: begin
            // Fill pulse is high during this cycle only.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state                 <= S_IDLE;
         owner_dcache          <= 1'b0;
         mem_req_valid_out     <= 1'b0;
         mem_we_out            <= 1'b0;
         mem_addr_out          <= '0;
         mem_wdata_out         <= '0;
         icache_fill_valid_out <= 1'b0;
         icache_fill_data_out  <= '0;
         dcache_fill_valid_out <= 1'b0;
         dcache_fill_data_out  <= '0;
      end else begin
         state                 <= state_d;
         owner_dcache          <= owner_dcache_d;
         mem_req_valid_out     <= req_valid_d;
         mem_we_out            <= we_d;
         mem_addr_out          <= addr_d;
         mem_wdata_out         <= wdata_d;
         icache_fill_valid_out <= ifill_valid_d;
         icache_fill_data_out  <= ifill_data_d;
         dcache_fill_valid_out <= dfill_valid_d;
         dcache_fill_data_out  <= dfill_data_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A table of transaction records (request
//   pattern, memory ready/response delays, response data, expected owner and
//   request fields) is applied in a loop; reset-during-WAIT and a request
//   dropped during ISSUE are covered by hand-written sequences. The dcache
//   fill-data model tracks the last refilled line so write acks can be checked
//   for holding it.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;

   logic          clk;
   logic          rst_n;
   logic          icache_req;
   logic [AW-1:0] icache_addr;
   logic          icache_fill_valid;
   logic [LW-1:0] icache_fill_data;
   logic          dcache_req;
   logic          dcache_we;
   logic [AW-1:0] dcache_addr;
   logic [LW-1:0] dcache_wdata;
   logic          dcache_fill_valid;
   logic [LW-1:0] dcache_fill_data;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic          mem_resp_valid;
   logic [LW-1:0] mem_resp_data;
   logic [1:0]    dbg_state;

   mem_arbiter #(.ADDR_BITS(AW), .LINE_BITS(LW)) dut (
      .clk_in                (clk),
      .rst_n_in              (rst_n),
      .icache_req_in         (icache_req),
      .icache_addr_in        (icache_addr),
      .icache_fill_valid_out (icache_fill_valid),
      .icache_fill_data_out  (icache_fill_data),
      .dcache_req_in         (dcache_req),
      .dcache_we_in          (dcache_we),
      .dcache_addr_in        (dcache_addr),
      .dcache_wdata_in       (dcache_wdata),
      .dcache_fill_valid_out (dcache_fill_valid),
      .dcache_fill_data_out  (dcache_fill_data),
      .mem_req_valid_out     (mem_req_valid),
      .mem_req_ready_in      (mem_req_ready),
      .mem_we_out            (mem_we),
      .mem_addr_out          (mem_addr),
      .mem_wdata_out         (mem_wdata),
      .mem_resp_valid_in     (mem_resp_valid),
      .mem_resp_data_in      (mem_resp_data),
      .dbg_state             (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [LW-1:0] exp_q[$];
   logic [LW-1:0] last_dfill;

   task automatic check(input string name, input logic [LW-1:0] act,
                        input logic [LW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Both fill pulses must never coincide.
   always @(negedge clk) begin
      if (rst_n && (icache_fill_valid || dcache_fill_valid)) begin
         n_tests++;
         if (icache_fill_valid && dcache_fill_valid) begin
            n_fail++;
            $display("FAIL dual_pulse: got 1 1 expected one pulse");
         end
      end
   end

   function automatic logic [LW-1:0] mem_model(input logic [AW-1:0] a);
      return {4{a ^ 32'hDEAD_0000}};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic          ireq;
      logic          dreq;
      logic          dwe;
      logic [AW-1:0] iaddr;
      logic [AW-1:0] daddr;
      logic [LW-1:0] dwdata;
      int            rdy_dly;
      int            rsp_dly;
      logic [LW-1:0] rdata;
      logic          exp_d;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
   } vec_t;

   function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                               input logic [AW-1:0] ia, input logic [AW-1:0] da,
                               input logic [LW-1:0] wd, input int rd, input int rs,
                               input logic [LW-1:0] rdat, input logic ed);
      vec_t v;
      v.ireq = ir; v.dreq = dr; v.dwe = dw; v.iaddr = ia; v.daddr = da;
      v.dwdata = wd; v.rdy_dly = rd; v.rsp_dly = rs; v.rdata = rdat;
      v.exp_d = ed; v.exp_we = ed & dw; v.exp_addr = ed ? da : ia;
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic run_vec(input vec_t v, input int idx);
      int            valid_cycles;
      logic [LW-1:0] exp_fill;
      exp_fill = (v.exp_d && v.exp_we) ? last_dfill : v.rdata;
      if (v.exp_d && !v.exp_we) last_dfill = v.rdata;
      exp_q.push_back(exp_fill);

      icache_req = v.ireq; icache_addr = v.iaddr;
      dcache_req = v.dreq; dcache_we = v.dwe;
      dcache_addr = v.daddr; dcache_wdata = v.dwdata;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

      @(posedge clk); #1;
      check($sformatf("v%0d_req_valid", idx), {127'd0, mem_req_valid}, 128'd1);
      check($sformatf("v%0d_we", idx), {127'd0, mem_we}, {127'd0, v.exp_we});
      check($sformatf("v%0d_addr", idx), {96'd0, mem_addr}, {96'd0, v.exp_addr});
      if (v.exp_we)
         check($sformatf("v%0d_wdata", idx), mem_wdata, v.dwdata);
      valid_cycles = 1;
      for (int k = 0; k < v.rdy_dly; k++) begin
         @(posedge clk); #1;
         if (mem_req_valid) valid_cycles++;
         check($sformatf("v%0d_addr_hold", idx), {96'd0, mem_addr}, {96'd0, v.exp_addr});
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      check($sformatf("v%0d_valid_cycles", idx), valid_cycles, v.rdy_dly + 1);
      check($sformatf("v%0d_valid_drop", idx), {127'd0, mem_req_valid}, 128'd0);
      for (int k = 0; k < v.rsp_dly; k++) begin
         @(posedge clk); #1;
      end
      check($sformatf("v%0d_no_early_fill", idx),
            {126'd0, icache_fill_valid, dcache_fill_valid}, 128'd0);
      mem_resp_valid = 1'b1; mem_resp_data = v.rdata;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      exp_fill = exp_q.pop_front();
      check($sformatf("v%0d_pulse", idx), {126'd0, icache_fill_valid, dcache_fill_valid},
            v.exp_d ? 128'd1 : 128'd2);
      if (v.exp_d) begin
         check($sformatf("v%0d_dfill_data", idx), dcache_fill_data, exp_fill);
         dcache_req = 1'b0;
      end else begin
         check($sformatf("v%0d_ifill_data", idx), icache_fill_data, exp_fill);
         icache_req = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_end", idx),
            {126'd0, icache_fill_valid, dcache_fill_valid}, 128'd0);
      check($sformatf("v%0d_idle", idx), {126'd0, dbg_state}, 128'd0);
   endtask

   // ---------------- test ----------------
   vec_t vecs[13];

   initial begin
      logic [LW-1:0] di, dd;
      di = {4{32'h1111_2222}};
      dd = {4{32'h3333_4444}};
      vecs[0] = mk(1, 0, 0, 32'h1000, 32'h0, '0, 0, 2, {16{8'hA5}}, 0);
      vecs[1] = mk(0, 1, 1, 32'h0, 32'h2000, 128'h1234, 3, 1, {4{32'hFFFF_0000}}, 1);
      vecs[2] = mk(0, 1, 0, 32'h0, 32'h3040, '0, 1, 0,
                   128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1);
`ifdef ARB_ROUND_ROBIN_EN
      // Last grant was dcache, so the tie goes to icache first.
      vecs[3] = mk(1, 1, 0, 32'h4000, 32'h5000, '0, 0, 0, di, 0);
      vecs[4] = mk(0, 1, 0, 32'h4000, 32'h5000, '0, 0, 0, dd, 1);
`else
      vecs[3] = mk(1, 1, 0, 32'h4000, 32'h5000, '0, 0, 0, dd, 1);
      vecs[4] = mk(1, 0, 0, 32'h4000, 32'h5000, '0, 0, 0, di, 0);
`endif
      for (int j = 0; j < 8; j++) begin
         logic [AW-1:0] ia, da;
         logic          w;
         ia = 32'h0001_0000 + 32'(j) * 32'h40;
         da = 32'h0002_0000 + 32'(j) * 32'h40;
         w  = (j % 4 == 3);
         if (j % 2 == 0)
            vecs[5+j] = mk(1, 0, 0, ia, 32'h0, '0, $urandom_range(0, 5),
                           $urandom_range(0, 5), mem_model(ia), 0);
         else
            vecs[5+j] = mk(0, 1, w, 32'h0, da, {4{~da}}, $urandom_range(0, 5),
                           $urandom_range(0, 5),
                           w ? {4{32'hBAD0_0000 | 32'(j)}} : mem_model(da), 1);
      end

      last_dfill = '0;
      rst_n = 1'b0;
      icache_req = 0; icache_addr = '0; dcache_req = 0; dcache_we = 0;
      dcache_addr = '0; dcache_wdata = '0; mem_req_ready = 0;
      mem_resp_valid = 0; mem_resp_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", {126'd0, dbg_state}, 128'd0);
      check("rst_valids", {125'd0, mem_req_valid, icache_fill_valid, dcache_fill_valid}, 128'd0);
      check("rst_we", {127'd0, mem_we}, 128'd0);
      check("rst_addr", {96'd0, mem_addr}, 128'd0);
      check("rst_wdata", mem_wdata, 128'd0);
      check("rst_fill_data", icache_fill_data | dcache_fill_data, 128'd0);
      rst_n = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("idle_no_req", {125'd0, dbg_state, mem_req_valid}, 128'd0);

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // Reset while WAITing, then a stale response must be ignored.
      icache_req = 1'b1; icache_addr = 32'h7700;
      @(posedge clk); #1;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      check("rw_in_wait", {126'd0, dbg_state}, 128'd2);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; icache_req = 1'b0;
      check("rw_state", {126'd0, dbg_state}, 128'd0);
      check("rw_req_valid", {127'd0, mem_req_valid}, 128'd0);
      check("rw_addr", {96'd0, mem_addr}, 128'd0);
      check("rw_fill_data", icache_fill_data | dcache_fill_data, 128'd0);
      mem_resp_valid = 1'b1; mem_resp_data = {4{32'hCAFE_F00D}};
      repeat (2) begin
         @(posedge clk); #1;
         check("rw_stale_pulse", {126'd0, icache_fill_valid, dcache_fill_valid}, 128'd0);
         check("rw_stale_state", {126'd0, dbg_state}, 128'd0);
      end
      mem_resp_valid = 1'b0; mem_resp_data = '0;

      // icache request withdrawn during ISSUE still completes.
      icache_req = 1'b1; icache_addr = 32'h8800;
      @(posedge clk); #1;
      icache_req = 1'b0;
      check("drop_valid", {127'd0, mem_req_valid}, 128'd1);
      repeat (2) begin
         @(posedge clk); #1;
         check("drop_hold", {96'd0, mem_addr}, {96'd0, 32'h8800});
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = mem_model(32'h8800);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      check("drop_pulse", {126'd0, icache_fill_valid, dcache_fill_valid}, 128'd2);
      check("drop_data", icache_fill_data, mem_model(32'h8800));
      @(posedge clk); #1;
      check("drop_idle", {125'd0, dbg_state, mem_req_valid}, 128'd0);
      repeat (2) @(posedge clk);
      #1;
      check("drop_no_regrant", {127'd0, mem_req_valid}, 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
